// File: rtl/regfile_wb_arbiter.sv
// Shares the single register-file write port between the writeback stage and
// an in-order side buffer of long-latency (mul/div) results, with anti-starvation.
module regfile_wb_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        lu_valid,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wdata,
  output logic        pipe_stall
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]    starve_q, starve_d;
  logic [4:0]    mem_rd_q   [DEPTH];
  logic [31:0]   mem_data_q [DEPTH];

  logic pipe_req, buf_req, force_buf, push, pop;

  // Grant decision; reset gates the pipeline request so nothing is written while held.
  always_comb begin
    pipe_req   = rst && wb_valid && (wb_rd != 5'd0);
    buf_req    = (count_q != '0);
    force_buf  = buf_req && pipe_req && (starve_q == 4'(STARVE_MAX));
    pop        = buf_req && (!pipe_req || force_buf);
    lu_ready   = (count_q < CW'(DEPTH));
    push       = rst && lu_valid && lu_ready && (lu_rd != 5'd0);
    rf_we      = 1'b0;
    rf_rd      = 5'd0;
    rf_wdata   = 32'd0;
    pipe_stall = force_buf;
    if (pipe_req && !force_buf) begin
      rf_we    = 1'b1;
      rf_rd    = wb_rd;
      rf_wdata = wb_data;
    end else if (pop) begin
      rf_we    = 1'b1;
      rf_rd    = mem_rd_q[rd_ptr_q];
      rf_wdata = mem_data_q[rd_ptr_q];
    end
  end

  always_comb begin
    count_d  = count_q + CW'(push) - CW'(pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    starve_d = starve_q;
    if (push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    if (pop || !buf_req)                   starve_d = 4'd0;
    else if (starve_q < 4'(STARVE_MAX))    starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      starve_q <= 4'd0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      starve_q <= starve_d;
    end
  end

  // Payload storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd_q[wr_ptr_q]   <= lu_rd;
      mem_data_q[wr_ptr_q] <= lu_data;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a queue-based model.
module tb_regfile_wb_arbiter;
  localparam int DEPTH = 2;
  localparam int SM    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        lu_valid = 1'b0;
  logic [4:0]  lu_rd = '0;
  logic [31:0] lu_data = '0;
  logic        lu_ready, rf_we, pipe_stall;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;

  int total = 0;
  int bad   = 0;

  typedef struct packed { logic [4:0] rd; logic [31:0] d; } ent_t;
  ent_t q[$];
  int   starve = 0;
  logic [39:0] exp_v;
  logic [39:0] obs_v;

  assign obs_v = {rf_we, rf_rd, rf_wdata, pipe_stall, lu_ready};

  regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data),
    .lu_ready(lu_ready), .rf_we(rf_we), .rf_rd(rf_rd),
    .rf_wdata(rf_wdata), .pipe_stall(pipe_stall)
  );

  always #5 clk = ~clk;

  // Expected port values from the model: a FIFO of pending results plus a blocked-cycle count.
  function automatic void predict();
    bit p, b, f;
    exp_v = 40'h1;
    if (!rst) return;
    p = wb_valid && (wb_rd != 5'd0);
    b = (q.size() != 0);
    f = b && p && (starve == SM);
    exp_v[0] = (q.size() < DEPTH);
    if (p && !f)  exp_v[39:1] = {1'b1, wb_rd, wb_data, 1'b0};
    else if (b)   exp_v[39:1] = {1'b1, q[0].rd, q[0].d, f};
  endfunction

  task automatic tick();
    bit p, b, f, popd, rdy;
    int sz0;
    p    = wb_valid && (wb_rd != 5'd0);
    sz0  = q.size();
    b    = (sz0 != 0);
    f    = b && p && (starve == SM);
    popd = b && (!p || f);
    rdy  = (sz0 < DEPTH);
    @(posedge clk);
    if (!rst) begin
      q.delete();
      starve = 0;
    end else begin
      if (popd) void'(q.pop_front());
      if (lu_valid && rdy && lu_rd != 5'd0) q.push_back({lu_rd, lu_data});
      if (popd || sz0 == 0) starve = 0;
      else if (starve < SM) starve++;
    end
    #1;
  endtask

  task automatic idle_inputs();
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    lu_valid = 1'b0; lu_rd = '0; lu_data = '0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h11;
    lu_valid = 1'b1; lu_rd = 5'd6; lu_data = 32'h22;
    for (int i = 0; i < 2; i++) begin
      #4; total++;
      if (obs_v !== 40'h1) begin
        bad++; $display("FAIL reset_outputs got=%h want=%h", obs_v, 40'h1);
      end
      tick();
    end
    idle_inputs();
    #4; rst = 1'b1; #1;
    tick();
  endtask

  task automatic test_pipe_write();
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h11;
    predict(); #4; total++;
    if (obs_v !== {1'b1, 5'd5, 32'h11, 1'b0, 1'b1}) begin
      bad++; $display("FAIL pipe_write got=%h want=%h", obs_v, {1'b1, 5'd5, 32'h11, 1'b0, 1'b1});
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_lu_single();
    lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'hAB;
    #4; total++;
    if (obs_v !== 40'h1) begin
      bad++; $display("FAIL lu_accept got=%h want=%h", obs_v, 40'h1);
    end
    tick();
    idle_inputs();
    #4; total++;
    if (obs_v !== {1'b1, 5'd7, 32'hAB, 1'b0, 1'b1}) begin
      bad++; $display("FAIL lu_write got=%h want=%h", obs_v, {1'b1, 5'd7, 32'hAB, 1'b0, 1'b1});
    end
    tick();
    #4; total++;
    if (obs_v !== 40'h1) begin
      bad++; $display("FAIL lu_drained got=%h want=%h", obs_v, 40'h1);
    end
    tick();
  endtask

  task automatic test_full();
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h33;
    lu_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      lu_rd = 5'(10 + i); lu_data = 32'(32'h100 + i);
      predict(); #4; total++;
      if (obs_v !== exp_v) begin
        bad++; $display("FAIL full_seq cyc=%0d got=%h want=%h", i, obs_v, exp_v);
      end
      if (i == 2) begin
        total++;
        if (lu_ready !== 1'b0) begin
          bad++; $display("FAIL full_third_ready got=%b want=0", lu_ready);
        end
      end
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_starve();
    logic [39:0] want;
    wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h44;
    lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 32'h99;
    tick();
    lu_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) want = {1'b1, 5'd9, 32'h99, 1'b1, 1'b1};
      else if (i < 4) want = {1'b1, 5'd4, 32'h44, 1'b0, 1'b1};
      else want = {1'b1, 5'd4, 32'h44, 1'b0, 1'b1};
      #4; total++;
      if (obs_v !== want) begin
        bad++; $display("FAIL starve cyc=%0d got=%h want=%h", i, obs_v, want);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_rd0();
    lu_valid = 1'b1; lu_rd = 5'd0; lu_data = 32'hDEAD;
    for (int i = 0; i < 3; i++) begin
      predict(); #4; total++;
      if (obs_v !== 40'h1) begin
        bad++; $display("FAIL lu_rd0 cyc=%0d got=%h want=%h", i, obs_v, 40'h1);
      end
      tick();
    end
    idle_inputs();
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h55;
    #4; total++;
    if (obs_v !== 40'h1) begin
      bad++; $display("FAIL wb_rd0 got=%h want=%h", obs_v, 40'h1);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h33;
    lu_valid = 1'b1; lu_rd = 5'd12; lu_data = 32'hC;
    tick();
    lu_rd = 5'd13; lu_data = 32'hD;
    tick();
    lu_valid = 1'b0;
    rst = 1'b0;
    #4; total++;
    if (obs_v !== 40'h1) begin
      bad++; $display("FAIL mid_reset_hold got=%h want=%h", obs_v, 40'h1);
    end
    tick();
    rst = 1'b1;
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      #4; total++;
      if (obs_v !== 40'h1) begin
        bad++; $display("FAIL mid_reset_after cyc=%0d got=%h want=%h", i, obs_v, 40'h1);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (!(exp_v[1] && i > 0)) begin
        wb_valid = ($urandom_range(0, 3) != 0);
        wb_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        wb_data  = $urandom;
      end
      lu_valid = ($urandom_range(0, 2) == 0);
      lu_rd    = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      lu_data  = $urandom;
      predict(); #4; total++;
      if (obs_v !== exp_v) begin
        bad++; $display("FAIL random cyc=%0d got=%h want=%h", i, obs_v, exp_v);
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_pipe_write();
    test_lu_single();
    test_full();
    test_starve();
    test_rd0();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter DEPTH, default 2, meaning side-buffer entries for long-latency results (legal 1..8).
REQ-002 Parameter STARVE_MAX, default 4, meaning consecutive blocked cycles before a buffered result is forced onto the port (legal 1..15).
REQ-003 Port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-low.
REQ-005 Port wb_valid  input  1  writeback stage holds an instruction that writes the register file.
REQ-006 Port wb_rd  input  5  writeback destination register.
REQ-007 Port wb_data  input  32  writeback value (regfile mux output).
REQ-008 Port lu_valid  input  1  long-latency unit (mul/div) result available.
REQ-009 Port lu_rd  input  5  long-latency destination register.
REQ-010 Port lu_data  input  32  long-latency result.
REQ-011 Port lu_ready  output  1  arbiter accepts lu result this cycle.
REQ-012 Port rf_we  output  1  register file write enable.
REQ-013 Port rf_rd  output  5  register file write index.
REQ-014 Port rf_wdata  output  32  register file write data.
REQ-015 Port pipe_stall  output  1  pipeline must hold writeback and all earlier stages this cycle.

Function
REQ-016 lu handshake: transfer occurs iff lu_valid && lu_ready; lu_ready = (count < DEPTH), combinational from registered count only.
REQ-017 Accepted lu result with lu_rd != 0 shall be pushed into an in-order FIFO at the clock edge; lu_rd == 0 shall be accepted and discarded.
REQ-018 Pushed entry is writable no earlier than the cycle after acceptance (no same-cycle bypass).
REQ-019 Port grant per cycle, evaluated combinationally: pipe_req = wb_valid && wb_rd != 0; buf_req = count != 0.
REQ-020 force = buf_req && pipe_req && (starve == STARVE_MAX).
REQ-021 If pipe_req && !force: rf_we=1, rf_rd=wb_rd, rf_wdata=wb_data, pipe_stall=0.
REQ-022 If buf_req && (!pipe_req || force): rf_we=1, rf_rd/rf_wdata = FIFO head, head popped at edge.
REQ-023 pipe_stall = force; pipeline inputs shall be held stable while stalled and written on a later grant.
REQ-024 If neither request: rf_we=0, rf_rd=0, rf_wdata=0.
REQ-025 starve counter (4 bits): cleared on pop or when count==0; incremented when buf_req && not popped; saturates at STARVE_MAX.
REQ-026 Push and pop in the same cycle shall leave count unchanged, FIFO order preserved; a pop in a full cycle shall not raise lu_ready in that same cycle.
REQ-027 Pointers wrap modulo DEPTH; count range 0..DEPTH, never exceeds DEPTH.
REQ-028 WAW ordering between pipeline and buffered writes to the same rd is guaranteed by issue logic; the arbiter performs no rd comparison.
REQ-029 wb_valid with wb_rd == 0 shall never assert rf_we for the pipeline and frees the port for the buffer.

Reset
REQ-030 While rst=0: count=0, pointers=0, starve=0, buffered entries discarded; outputs rf_we=0, rf_rd=0, rf_wdata=0, pipe_stall=0, lu_ready=1.
REQ-031 Reset asserted mid-operation shall drop pending entries immediately, without writing them; first grant possible in the first cycle after rst rises.

Verification
REQ-032 Idle after reset, wb_valid=1 rd=5 data=0x11 -> same cycle rf_we=1 rf_rd=5 rf_wdata=0x11, pipe_stall=0.
REQ-033 lu_valid rd=7 data=0xAB with wb_valid=0 -> accepted cycle N, rf_we=1 rd=7 data=0xAB in cycle N+1, count back to 0.
REQ-034 DEPTH=2: three consecutive lu_valid while wb_valid=1 rd=3 -> first two accepted, lu_ready=0 on third until a pop occurs.
REQ-035 Buffer holds rd=9, wb_valid=1 rd=4 every cycle, STARVE_MAX=4 -> pipeline writes 4 cycles, 5th cycle rd=9 written with pipe_stall=1, next cycle rd=4 written, pipe_stall=0.
REQ-036 lu_valid rd=0 -> lu_ready=1, count stays 0, rf_we never asserted for it.
REQ-037 Two entries buffered, rst pulsed low one cycle -> no rf_we for either entry, lu_ready=1, count=0 after release.
